rs_station: RTL

Reservation station for one execution unit, directly downstream of the ID/EX register. Accepts decoded entries (unit id, op, two operand tag/value pairs, ROB target) and holds them until both operands are available. It snoops the common data bus (CDB) to capture pending operands, then issues the oldest ready entry to its functional unit over a valid/ready handshake.

---
 rtl/scipio_pkg.sv | 44 ++++
 rtl/rs_select.sv | 27 ++
 rtl/rs_station.sv | 136 +++++++++++++
 3 files changed

// File: rtl/scipio_pkg.sv
// rtl/scipio_pkg.sv - shared widths, reservation-station entry type and operand helpers
package scipio_pkg;

    localparam int EX_UNIT_NUM_WIDTH = 2;
    localparam int INST_OP_WIDTH     = 4;
    localparam int INST_TAG_WIDTH    = 4;
    localparam int COMMON_WIDTH      = 16;

    // A tag of zero means the operand value is already held in the entry
    localparam logic [INST_TAG_WIDTH-1:0] TAG_READY = '0;

    typedef struct packed {
        logic                                valid;
        logic [INST_OP_WIDTH-1:0]            op;
        logic [1:2][INST_TAG_WIDTH-1:0]      tag;
        logic [1:2][COMMON_WIDTH-1:0]        val;
        logic [INST_TAG_WIDTH-1:0]           target;
    } rs_entry_t;

    // Capture a CDB broadcast into any operand of a live entry still waiting on that tag
    function automatic rs_entry_t rs_wakeup(
        input rs_entry_t                 e,
        input logic                      bcast_valid,
        input logic [INST_TAG_WIDTH-1:0] bcast_tag,
        input logic [COMMON_WIDTH-1:0]   bcast_val
    );
        rs_entry_t r;
        r = e;
        if (r.valid && bcast_valid && (bcast_tag != TAG_READY)) begin
            for (int k = 1; k <= 2; k++) begin
                if (r.tag[k] == bcast_tag) begin
                    r.val[k] = bcast_val;
                    r.tag[k] = TAG_READY;
                end
            end
        end
        return r;
    endfunction

    function automatic logic rs_is_ready(input rs_entry_t e);
        return e.valid && (e.tag[1] == TAG_READY) && (e.tag[2] == TAG_READY);
    endfunction

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - lowest-index priority picker over the ready vector
module rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req_i,
    output logic [DEPTH-1:0]         grant_o,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic                     any_o
);

    localparam int IW = $clog2(DEPTH);

    // Scan from the top so the lowest requesting index is the last writer
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// rtl/rs_station.sv - collapsing-queue reservation station with CDB wakeup and oldest-ready issue
module rs_station
    import scipio_pkg::*;
#(
    parameter int                           DEPTH   = 4,
    parameter logic [EX_UNIT_NUM_WIDTH-1:0] UNIT_ID = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [EX_UNIT_NUM_WIDTH-1:0]   in_ex_unit,
    input  logic [INST_OP_WIDTH-1:0]       in_op,
    input  logic [INST_TAG_WIDTH-1:0]      in_tag1,
    input  logic [INST_TAG_WIDTH-1:0]      in_tag2,
    input  logic [COMMON_WIDTH-1:0]        in_val1,
    input  logic [COMMON_WIDTH-1:0]        in_val2,
    input  logic [INST_TAG_WIDTH-1:0]      in_target,
    output logic                           in_ready,
    input  logic                           cdb_valid,
    input  logic [INST_TAG_WIDTH-1:0]      cdb_tag,
    input  logic [COMMON_WIDTH-1:0]        cdb_val,
    input  logic                           flush,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [INST_OP_WIDTH-1:0]       issue_op,
    output logic [COMMON_WIDTH-1:0]        issue_val1,
    output logic [COMMON_WIDTH-1:0]        issue_val2,
    output logic [INST_TAG_WIDTH-1:0]      issue_target,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    rs_entry_t        shift_src [DEPTH+1];
    rs_entry_t        new_entry;
    logic [CW-1:0]    count_q, count_d, count_after;
    logic [DEPTH-1:0] ready_vec, grant;
    logic [IW-1:0]    sel_idx;
    logic             any_ready, do_issue, do_insert;

    // An entry can issue once both operand tags have been resolved
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = rs_is_ready(entries_q[i]);
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_select (
        .req_i   (ready_vec),
        .grant_o (grant),
        .idx_o   (sel_idx),
        .any_o   (any_ready)
    );

    // Handshake status depends only on registered state and flush, never on the partner's signal
    assign in_ready    = (count_q != CW'(DEPTH));
    assign issue_valid = any_ready && !flush;
    assign count       = count_q;
    assign do_issue    = issue_valid && issue_ready;
    assign do_insert   = in_valid && (in_ex_unit == UNIT_ID) && in_ready && !flush;
    assign count_after = count_q - CW'(do_issue);

    // Present the granted slot's registered contents; all-zero when nothing is granted
    always_comb begin
        issue_op     = '0;
        issue_val1   = '0;
        issue_val2   = '0;
        issue_target = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_op     = entries_q[i].op;
                issue_val1   = entries_q[i].val[1];
                issue_val2   = entries_q[i].val[2];
                issue_target = entries_q[i].target;
            end
        end
    end

    // Collapse over the issued slot, apply wakeup, then append the new entry at the shrunken tail
    always_comb begin
        new_entry        = '0;
        new_entry.valid  = 1'b1;
        new_entry.op     = in_op;
        new_entry.tag[1] = in_tag1;
        new_entry.tag[2] = in_tag2;
        new_entry.val[1] = in_val1;
        new_entry.val[2] = in_val2;
        new_entry.target = in_target;
        new_entry        = rs_wakeup(new_entry, cdb_valid, cdb_tag, cdb_val);

        for (int i = 0; i < DEPTH; i++) begin
            shift_src[i] = entries_q[i];
        end
        shift_src[DEPTH] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && (i >= int'(sel_idx))) begin
                entries_d[i] = shift_src[i+1];
            end else begin
                entries_d[i] = shift_src[i];
            end
            entries_d[i] = rs_wakeup(entries_d[i], cdb_valid, cdb_tag, cdb_val);
            if (do_insert && (i == int'(count_after))) begin
                entries_d[i] = new_entry;
            end
        end
        count_d = count_after + CW'(do_insert);

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end
    end

    // State register; reset clears every slot so data outputs read as zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule
